// File: rtl/pattern_pkg.sv
// Shared constants for the note-pattern sequencer: pattern width, LFSR taps,
// default row count and the fixed chart, plus the LFSR step/pattern helpers.
// Ports: none (package).
package pattern_pkg;

  localparam int PAT_W          = 4;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int DEFAULT_N_ROWS = 4;
  localparam int CHART_DEPTH    = 16;

  typedef logic [PAT_W-1:0] pat_t;

  // Fixed note chart; zero entries are deliberate empty rows.
  localparam pat_t CHART [CHART_DEPTH] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h0, 4'h6, 4'hC,
    4'h5, 4'hA, 4'h9, 4'h0, 4'hF, 4'h7, 4'hE, 4'hB
  };

  // Galois LFSR, shift right, taps folded in when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // A random pattern must never be empty, so a zero nibble becomes 4'b1000.
  function automatic pat_t lfsr_pat(input logic [15:0] s);
    return (s[3:0] == 4'h0) ? 4'b1000 : s[3:0];
  endfunction

endpackage

// File: rtl/chart_rom.sv
// Combinational chart lookup: returns the pattern stored at ptr.
// Latency: zero cycles (pure lookup). No flow control.
// Ports: ptr (chart index) in, pat (4-bit pattern) out.
module chart_rom
  import pattern_pkg::*;
#(
  parameter int CHART_LEN = 16,
  parameter int PTR_W     = 4
) (
  input  logic [PTR_W-1:0] ptr,
  output pat_t             pat
);

  logic [3:0] idx;

  // The stored chart holds CHART_DEPTH entries; the pointer never exceeds
  // CHART_LEN-1, so only the low index bits are meaningful.
  always_comb begin
    idx = 4'(ptr);
    pat = CHART[idx];
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Keeps a pre-fetched next pattern in every row slot and refills one slot per
// cycle after a hand-over; scores hits and unanswered non-empty patterns.
// Latency: request at edge k -> slot refilled at edge k+1+(lower rows pending);
// counters update on the edge that samples the input rise.
// Backpressure: one outstanding refill per row; a second request on a pending
// row is dropped and sets the sticky overflow flag.
// Ports: CLOCK_25, reset_n (sync, active-low), mode (0 LFSR / 1 chart),
// trocar/ponto per-row request/hit levels, command_out row slots,
// score/streak/misses counters, busy (refill pending), overflow (sticky).
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int          N_ROWS    = DEFAULT_N_ROWS,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          CHART_LEN = 16,
  parameter int          SCORE_W   = 16
) (
  input  logic                      CLOCK_25,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [N_ROWS-1:0]         trocar,
  input  logic [N_ROWS-1:0]         ponto,
  output logic [PAT_W*N_ROWS-1:0]   command_out,
  output logic [SCORE_W-1:0]        score,
  output logic [7:0]                streak,
  output logic [SCORE_W-1:0]        misses,
  output logic                      busy,
  output logic                      overflow
);

  localparam int PTR_W = (CHART_LEN > 1) ? $clog2(CHART_LEN) : 1;
  localparam int CNT_W = $clog2(N_ROWS + 1);

  logic [N_ROWS-1:0]       trocar_prev_q, trocar_prev_d;
  logic [N_ROWS-1:0]       ponto_prev_q,  ponto_prev_d;
  logic [PAT_W*N_ROWS-1:0] cmd_q,         cmd_d;
  logic [PAT_W*N_ROWS-1:0] prev_pat_q,    prev_pat_d;
  logic [N_ROWS-1:0]       pending_q,     pending_d;
  logic [N_ROWS-1:0]       scored_q,      scored_d;
  logic [15:0]             lfsr_q,        lfsr_d;
  logic [PTR_W-1:0]        ptr_q,         ptr_d;
  logic [SCORE_W-1:0]      score_q,       score_d;
  logic [SCORE_W-1:0]      misses_q,      misses_d;
  logic [7:0]              streak_q,      streak_d;
  logic                    overflow_q,    overflow_d;

  logic [N_ROWS-1:0]  req, hit, hit_ev, miss_ev, prev_nz, serve_oh;
  logic [CNT_W-1:0]   hit_cnt, miss_cnt;
  logic [SCORE_W:0]   score_sum, misses_sum;
  logic [8:0]         streak_sum;
  pat_t               chart_pat, gen_pat;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_ROWS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_ROWS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  chart_rom #(
    .CHART_LEN (CHART_LEN),
    .PTR_W     (PTR_W)
  ) u_chart_rom (
    .ptr (ptr_q),
    .pat (chart_pat)
  );

  always_comb begin
    req = trocar & ~trocar_prev_q;
    hit = ponto  & ~ponto_prev_q;

    // Lowest set bit of the pending mask is the row served this cycle.
    serve_oh = pending_q & (~pending_q + N_ROWS'(1));
    gen_pat  = mode ? chart_pat : lfsr_pat(lfsr_q);

    for (int i = 0; i < N_ROWS; i++) prev_nz[i] = |prev_pat_q[PAT_W*i +: PAT_W];

    // A hit arriving with the request belongs to the outgoing pattern, so it
    // answers that pattern and suppresses the miss.
    hit_ev   = hit & ~scored_q;
    miss_ev  = req & prev_nz & ~scored_q & ~hit_ev;
    hit_cnt  = popcount(hit_ev);
    miss_cnt = popcount(miss_ev);

    score_sum  = {1'b0, score_q}  + (SCORE_W+1)'(hit_cnt);
    misses_sum = {1'b0, misses_q} + (SCORE_W+1)'(miss_cnt);
    streak_sum = {1'b0, streak_q} + 9'(hit_cnt);

    trocar_prev_d = trocar;
    ponto_prev_d  = ponto;
    cmd_d         = cmd_q;
    prev_pat_d    = prev_pat_q;
    lfsr_d        = lfsr_q;
    ptr_d         = ptr_q;

    pending_d  = (pending_q & ~serve_oh) | (req & ~pending_q);
    overflow_d = overflow_q | (|(req & pending_q));
    scored_d   = (scored_q | hit_ev) & ~req;

    for (int i = 0; i < N_ROWS; i++) begin
      if (serve_oh[i]) cmd_d[PAT_W*i +: PAT_W] = gen_pat;
      if (req[i])      prev_pat_d[PAT_W*i +: PAT_W] = cmd_q[PAT_W*i +: PAT_W];
    end

    // Only the selected source advances, and only when a row is served.
    if (|pending_q) begin
      if (mode) ptr_d = (ptr_q == PTR_W'(CHART_LEN - 1)) ? '0 : ptr_q + PTR_W'(1);
      else      lfsr_d = lfsr_step(lfsr_q);
    end

    score_d  = score_sum[SCORE_W]  ? '1 : score_sum[SCORE_W-1:0];
    misses_d = misses_sum[SCORE_W] ? '1 : misses_sum[SCORE_W-1:0];
    if (|miss_ev)          streak_d = 8'h00;
    else if (streak_sum[8]) streak_d = 8'hFF;
    else                    streak_d = streak_sum[7:0];
  end

  always_ff @(posedge CLOCK_25) begin
    if (!reset_n) begin
      trocar_prev_q <= '0;
      ponto_prev_q  <= '0;
      cmd_q         <= '0;
      prev_pat_q    <= '0;
      pending_q     <= '1;
      scored_q      <= '0;
      lfsr_q        <= SEED;
      ptr_q         <= '0;
      score_q       <= '0;
      misses_q      <= '0;
      streak_q      <= '0;
      overflow_q    <= 1'b0;
    end else begin
      trocar_prev_q <= trocar_prev_d;
      ponto_prev_q  <= ponto_prev_d;
      cmd_q         <= cmd_d;
      prev_pat_q    <= prev_pat_d;
      pending_q     <= pending_d;
      scored_q      <= scored_d;
      lfsr_q        <= lfsr_d;
      ptr_q         <= ptr_d;
      score_q       <= score_d;
      misses_q      <= misses_d;
      streak_q      <= streak_d;
      overflow_q    <= overflow_d;
    end
  end

  assign command_out = cmd_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign streak      = streak_q;
  assign overflow    = overflow_q;
  assign busy        = |pending_q;

endmodule
